// File: rtl/udp_tx_arb.sv
// Two-requester round-robin arbiter in front of a UDP frame generator.
// Enforces min/max payload length, a completion timeout and an inter-frame gap.
module udp_tx_arb #(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 18,
  parameter int MAX_LEN    = 1472,
  parameter int TIMEOUT    = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_len0,
  input  logic [15:0] i_len1,
  input  logic        i_done,
  output logic [1:0]  o_gnt,
  output logic        o_start,
  output logic        o_sel,
  output logic [15:0] o_len,
  output logic        o_err_len,
  output logic        o_timeout,
  output logic        o_idle,
  output logic [15:0] o_frames
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(IFG_CYCLES + 1);

  localparam logic [15:0]    MIN_LEN_L = 16'(MIN_LEN);
  localparam logic [15:0]    MAX_LEN_L = 16'(MAX_LEN);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'(IFG_CYCLES);

  logic [1:0]     r_state;
  logic           r_last;
  logic [WCW-1:0] r_wcnt;
  logic [GCW-1:0] r_gcnt;

  logic           w_win;
  logic [15:0]    w_len;
  logic [15:0]    w_len_adj;
  logic           w_too_long;
  logic           w_wait_exp;
  logic           w_gap_end;

  // Winner selection: on contention the requester not served last wins.
  always_comb begin
    w_win      = (i_req == 2'b11) ? ~r_last : i_req[1];
    w_len      = w_win ? i_len1 : i_len0;
    w_too_long = (w_len > MAX_LEN_L);
    w_len_adj  = (w_len < MIN_LEN_L) ? MIN_LEN_L : w_len;
    w_wait_exp = (r_wcnt == WAIT_LAST);
    w_gap_end  = (r_gcnt <= GCW'(1));
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_wcnt    <= '0;
      r_gcnt    <= '0;
      o_gnt     <= 2'b00;
      o_start   <= 1'b0;
      o_sel     <= 1'b0;
      o_len     <= 16'd0;
      o_err_len <= 1'b0;
      o_timeout <= 1'b0;
      o_idle    <= 1'b1;
      o_frames  <= 16'd0;
    end else begin
      o_gnt     <= 2'b00;
      o_start   <= 1'b0;
      o_err_len <= 1'b0;
      o_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req != 2'b00) begin
            o_gnt  <= w_win ? 2'b10 : 2'b01;
            r_last <= w_win;
            // Oversized requests are consumed and rejected without leaving IDLE.
            if (w_too_long) begin
              o_err_len <= 1'b1;
            end else begin
              o_start <= 1'b1;
              o_sel   <= w_win;
              o_len   <= w_len_adj;
              o_idle  <= 1'b0;
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // i_done takes precedence over a coincident timeout expiry.
          if (i_done) begin
            o_frames <= o_frames + 16'd1;
            r_gcnt   <= GAP_LOAD;
            r_state  <= S_GAP;
          end else if (w_wait_exp) begin
            o_timeout <= 1'b1;
            r_gcnt    <= GAP_LOAD;
            r_state   <= S_GAP;
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_gcnt  <= '0;
            o_idle  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt - GCW'(1);
          end
        end
        default: begin
          o_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed self-checking bench for udp_tx_arb with default parameters.
module tb_udp_tx_arb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [15:0] i_len0;
  logic [15:0] i_len1;
  logic        i_done;
  logic [1:0]  o_gnt;
  logic        o_start;
  logic        o_sel;
  logic [15:0] o_len;
  logic        o_err_len;
  logic        o_timeout;
  logic        o_idle;
  logic [15:0] o_frames;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  udp_tx_arb dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
    .i_done(i_done), .o_gnt(o_gnt), .o_start(o_start), .o_sel(o_sel), .o_len(o_len),
    .o_err_len(o_err_len), .o_timeout(o_timeout), .o_idle(o_idle), .o_frames(o_frames)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget, output logic found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (o_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    logic seen;
    seen = (o_idle === 1'b1);
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      seen = (o_idle === 1'b1);
    end
    chk("idle_reached", {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_done();
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
  endtask

  logic       found;
  logic [1:0] exp_gnt [3] = '{2'b01, 2'b10, 2'b01};
  logic [15:0] exp_len [3] = '{16'd100, 16'd200, 16'd100};
  int last_start;
  int n;

  initial begin
    i_rst = 1'b1; i_req = 2'b00; i_len0 = 16'd0; i_len1 = 16'd0; i_done = 1'b0;
    repeat (3) tick();
    chk("rst_idle", {31'd0, o_idle}, 32'd1);
    chk("rst_frames", {16'd0, o_frames}, 32'd0);
    chk("rst_gnt", {30'd0, o_gnt}, 32'd0);
    chk("rst_len", {16'd0, o_len}, 32'd0);
    i_rst = 1'b0;

    // Both requesters held: grants alternate, starts spaced by 19 cycles
    i_len0 = 16'd100; i_len1 = 16'd200; i_req = 2'b11;
    last_start = 0;
    for (int i = 0; i < 3; i++) begin
      wait_start(60, found);
      chk("rr_start_seen", {31'd0, found}, 32'd1);
      chk("rr_gnt", {30'd0, o_gnt}, {30'd0, exp_gnt[i]});
      chk("rr_sel", {31'd0, o_sel}, {31'd0, exp_gnt[i][1]});
      chk("rr_len", {16'd0, o_len}, {16'd0, exp_len[i]});
      chk("rr_idle_low", {31'd0, o_idle}, 32'd0);
      if (i > 0) chk("rr_spacing", cyc - last_start, 32'd19);
      last_start = cyc;
      if (i == 2) i_req = 2'b00;
      repeat (5) tick();
      chk("rr_len_stable", {16'd0, o_len}, {16'd0, exp_len[i]});
      pulse_done();
      chk("rr_frames", {16'd0, o_frames}, i + 1);
    end

    // Short length raised to MIN_LEN; i_done during START ignored
    wait_idle(40);
    i_len0 = 16'd10; i_req = 2'b01;
    wait_start(5, found);
    chk("min_start_seen", {31'd0, found}, 32'd1);
    chk("min_len", {16'd0, o_len}, 32'd18);
    chk("min_gnt", {30'd0, o_gnt}, 32'd1);
    i_req = 2'b00;
    pulse_done();
    chk("done_in_start_ignored", {16'd0, o_frames}, 32'd3);
    tick();
    pulse_done();
    chk("min_frames", {16'd0, o_frames}, 32'd4);

    wait_idle(40);
    i_len0 = 16'd200; i_req = 2'b01;
    wait_start(5, found);
    chk("len200_start_seen", {31'd0, found}, 32'd1);
    chk("len200_len", {16'd0, o_len}, 32'd200);
    i_req = 2'b00;
    tick();
    pulse_done();
    chk("len200_frames", {16'd0, o_frames}, 32'd5);

    // Oversized request on requester 1: grant + error, no start, stays IDLE
    wait_idle(40);
    i_len1 = 16'd1500; i_req = 2'b10;
    tick();
    chk("err_gnt", {30'd0, o_gnt}, 32'd2);
    chk("err_len_pulse", {31'd0, o_err_len}, 32'd1);
    chk("err_no_start", {31'd0, o_start}, 32'd0);
    chk("err_idle", {31'd0, o_idle}, 32'd1);
    i_req = 2'b00;
    tick();
    chk("err_pulse_end", {31'd0, o_err_len}, 32'd0);
    chk("err_idle_after", {31'd0, o_idle}, 32'd1);

    // Pointer advanced past requester 1, so requester 0 wins; then timeout
    i_len0 = 16'd50; i_len1 = 16'd60; i_req = 2'b11;
    wait_start(5, found);
    chk("to_start_seen", {31'd0, found}, 32'd1);
    chk("to_gnt", {30'd0, o_gnt}, 32'd1);
    i_req = 2'b00;
    last_start = cyc;
    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (o_timeout === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("to_seen", {31'd0, found}, 32'd1);
    chk("to_latency", cyc - last_start, 32'd4097);
    chk("to_frames", {16'd0, o_frames}, 32'd5);
    n = 0;
    while (o_idle !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_gap_len", n, 32'd12);

    // Reset during WAIT, then i_done ignored, then immediate grant
    i_req = 2'b10;
    wait_start(5, found);
    chk("rw_start_seen", {31'd0, found}, 32'd1);
    i_req = 2'b00;
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rw_idle", {31'd0, o_idle}, 32'd1);
    chk("rw_frames", {16'd0, o_frames}, 32'd0);
    chk("rw_len", {16'd0, o_len}, 32'd0);
    chk("rw_sel", {31'd0, o_sel}, 32'd0);
    chk("rw_flags", {28'd0, o_gnt, o_start, o_timeout}, 32'd0);
    pulse_done();
    chk("rw_done_ignored", {16'd0, o_frames}, 32'd0);
    chk("rw_still_idle", {31'd0, o_idle}, 32'd1);
    i_req = 2'b11;
    tick();
    chk("rw_first_gnt", {30'd0, o_gnt}, 32'd1);
    chk("rw_first_start", {31'd0, o_start}, 32'd1);
    i_req = 2'b00;
    tick();
    pulse_done();
    chk("rw_frames_one", {16'd0, o_frames}, 32'd1);

    // Frame counter wraps from 0xFFFF to 0
    wait_idle(40);
    force dut.o_frames = 16'hFFFF;
    tick();
    release dut.o_frames;
    tick();
    chk("wrap_preload", {16'd0, o_frames}, 32'h0000FFFF);
    i_len0 = 16'd20; i_req = 2'b01;
    wait_start(5, found);
    chk("wrap_start_seen", {31'd0, found}, 32'd1);
    i_req = 2'b00;
    tick();
    pulse_done();
    chk("wrap_frames", {16'd0, o_frames}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
